// File: rtl/sim_supervisor_pkg.sv
// Shared types and helpers for the run supervisor and its console FIFO.
package sim_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } sup_state_t;

    // Index width for a counter or pointer over depth values; never below 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned depth);
        int unsigned w;
        if (depth <= 32'd2) w = 32'd1;
        else                w = $unsigned($clog2(depth));
        return w;
    endfunction

endpackage

// File: rtl/sim_supervisor_fifo.sv
// First-word-fall-through synchronous FIFO holding the core's console bytes.
module sup_fifo
    import sim_supervisor_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full
);

    localparam int unsigned PTR_W = clog2_min1(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    logic              do_wr;
    logic              do_rd;

    // A pop frees a slot, so a full FIFO still accepts a write in the same cycle.
    assign do_rd      = rd_en && rd_valid;
    assign do_wr      = wr_en && (!full || do_rd);
    assign rd_ptr_nxt = do_rd ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        occ_nxt = occ;
        case ({do_wr, do_rd})
            2'b10:   occ_nxt = occ + OCC_W'(1);
            2'b01:   occ_nxt = occ - OCC_W'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Head is pre-fetched into rd_data; bypass when the written slot becomes the head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr   <= rd_ptr_nxt;
            occ      <= occ_nxt;
            rd_valid <= (occ_nxt != '0);
            full     <= (occ_nxt == OCC_W'(FIFO_DEPTH));
            if (occ_nxt != '0)
                rd_data <= (do_wr && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/sim_supervisor.sv
// Run supervisor: sequences core reset, counts run cycles, stops on trap or
// timeout, and buffers console output for a host to drain.
module sim_supervisor
    import sim_supervisor_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned RESET_CYCLES = 100,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_CYCLES   = 0
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              core_resetn,
    input  logic              trap,
    input  logic [DATA_W-1:0] out_byte,
    input  logic              out_byte_en,
    input  logic              restart,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              overflow,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned      HOLD_W    = clog2_min1(RESET_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 32'd1);
    localparam logic              TO_EN     = (MAX_CYCLES != 32'd0);

    sup_state_t        state;
    sup_state_t        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wr_req;
    logic              fifo_full;

    assign wr_req = out_byte_en && core_resetn;

    // Next-state decision; trap takes priority over the timeout budget.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (trap)                                  state_nxt = ST_DONE;
                else if (TO_EN && (cycle_count == CNT_LAST)) state_nxt = ST_TIMEOUT;
            end
            ST_DONE, ST_TIMEOUT: begin
                if (restart) state_nxt = ST_HOLD;
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    // State, counters and registered status decodes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            cycle_count <= '0;
            core_resetn <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            core_resetn <= (state_nxt != ST_HOLD);
            running     <= (state_nxt == ST_RUN);
            done        <= (state_nxt == ST_DONE);
            timeout     <= (state_nxt == ST_TIMEOUT);

            if ((state == ST_HOLD) && (state_nxt == ST_HOLD))
                hold_cnt <= hold_cnt + HOLD_W'(1);
            else
                hold_cnt <= '0;

            // Saturating run counter; cleared only when a restart re-enters HOLD.
            if (state == ST_RUN) begin
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            end else if (state_nxt == ST_HOLD) begin
                cycle_count <= '0;
            end

            if (wr_req && fifo_full && !(rd_en && rd_valid)) overflow <= 1'b1;
        end
    end

    sup_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_req),
        .wr_data  (out_byte),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full)
    );

endmodule
